// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock register-array FIFO of arbitrary depth with
// a fill count, programmable almost-full/almost-empty thresholds, sticky
// overflow/underflow flags and a selectable first-word-fall-through read port.
module sync_fifo_flags #(
   parameter int DEPTH     = 8,
   parameter int WIDTH     = 8,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 1,
   parameter bit FWFT      = 1'b0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       w_en,
   input  logic                       r_en,
   input  logic [WIDTH-1:0]           data_in,
   input  logic                       clr_err,
   output logic [WIDTH-1:0]           data_out,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic [CW-1:0]    cnt_q;
   logic             rd_ok, wr_ok;

   // Depth need not be a power of two, so wrap explicitly at DEPTH-1.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Flags come straight from the registered count.
   assign count        = cnt_q;
   assign empty        = (cnt_q == '0);
   assign full         = (cnt_q == CW'(DEPTH));
   assign almost_full  = (cnt_q >= CW'(AF_THRESH));
   assign almost_empty = (cnt_q <= CW'(AE_THRESH));

   // A write into a full FIFO only goes through when a read frees a slot
   // on the same edge; a read of an empty FIFO never bypasses the write.
   assign rd_ok = r_en & ~empty;
   assign wr_ok = w_en & (~full | rd_ok);

   // Storage array; not reset, contents are qualified by the count.
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= data_in;
   end

   // Pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
      end else begin
         if (wr_ok) wr_ptr <= ptr_inc(wr_ptr);
         if (rd_ok) rd_ptr <= ptr_inc(rd_ptr);
         if (wr_ok && !rd_ok)      cnt_q <= cnt_q + CW'(1);
         else if (rd_ok && !wr_ok) cnt_q <= cnt_q - CW'(1);
      end
   end

   // Sticky error flags; a new error on the clearing edge keeps the flag set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (w_en && !wr_ok) overflow <= 1'b1;
         else if (clr_err)   overflow <= 1'b0;
         if (r_en && !rd_ok) underflow <= 1'b1;
         else if (clr_err)   underflow <= 1'b0;
      end
   end

   generate
      if (FWFT) begin : g_fwft
         // Head word is shown as soon as it is stored; read pops it.
         assign data_out = empty ? '0 : mem[rd_ptr];
      end else begin : g_reg
         logic [WIDTH-1:0] dout_q;
         // Registered read: word appears the cycle after the accepted read.
         always_ff @(posedge clk or posedge rst) begin
            if (rst)        dout_q <= '0;
            else if (rd_ok) dout_q <= mem[rd_ptr];
         end
         assign data_out = dout_q;
      end
   endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: three instances (depth 8 registered, depth 5
// registered, depth 8 FWFT) share one stimulus stream and are each compared
// against a queue-level reference model every cycle.
module tb_sync_fifo_flags;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       w_en = 1'b0, r_en = 1'b0, clr_err = 1'b0;
   logic [7:0] data_in = '0;

   logic [7:0] dout [3];
   logic       full [3], empty [3], afull [3], aempty [3], ovf [3], udf [3];
   logic [3:0] cnt8a, cnt8b;
   logic [2:0] cnt5;

   int n_chk = 0;
   int n_err = 0;

   // Per-instance configuration
   int D  [3] = '{8, 5, 8};
   int AF [3] = '{6, 3, 6};
   int AE [3] = '{1, 1, 1};
   bit FW [3] = '{1'b0, 1'b0, 1'b1};

   // Reference model: contents as a circular list with head index and length
   logic [7:0] mm [3][8];
   int         mhead [3], mcnt [3];
   logic [7:0] mdout [3];
   bit         movf [3], mudf [3];

   always #5 clk = ~clk;

   sync_fifo_flags #(.DEPTH(8), .WIDTH(8), .AF_THRESH(6), .AE_THRESH(1), .FWFT(1'b0)) u_d8 (
      .clk(clk), .rst(rst), .w_en(w_en), .r_en(r_en), .data_in(data_in), .clr_err(clr_err),
      .data_out(dout[0]), .full(full[0]), .empty(empty[0]), .almost_full(afull[0]),
      .almost_empty(aempty[0]), .count(cnt8a), .overflow(ovf[0]), .underflow(udf[0]));

   sync_fifo_flags #(.DEPTH(5), .WIDTH(8), .AF_THRESH(3), .AE_THRESH(1), .FWFT(1'b0)) u_d5 (
      .clk(clk), .rst(rst), .w_en(w_en), .r_en(r_en), .data_in(data_in), .clr_err(clr_err),
      .data_out(dout[1]), .full(full[1]), .empty(empty[1]), .almost_full(afull[1]),
      .almost_empty(aempty[1]), .count(cnt5), .overflow(ovf[1]), .underflow(udf[1]));

   sync_fifo_flags #(.DEPTH(8), .WIDTH(8), .AF_THRESH(6), .AE_THRESH(1), .FWFT(1'b1)) u_fw (
      .clk(clk), .rst(rst), .w_en(w_en), .r_en(r_en), .data_in(data_in), .clr_err(clr_err),
      .data_out(dout[2]), .full(full[2]), .empty(empty[2]), .almost_full(afull[2]),
      .almost_empty(aempty[2]), .count(cnt8b), .overflow(ovf[2]), .underflow(udf[2]));

   task automatic chk(input string tag, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
      end
   endtask

   function automatic int get_cnt(input int i);
      case (i)
         0:       return int'(cnt8a);
         1:       return int'(cnt5);
         default: return int'(cnt8b);
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         mhead[i] = 0; mcnt[i] = 0; mdout[i] = '0; movf[i] = 0; mudf[i] = 0;
      end
   endtask

   // One clock edge of the abstract FIFO: pop head if possible, then append.
   task automatic model_edge(input bit w, input bit r, input logic [7:0] d, input bit clr);
      for (int i = 0; i < 3; i++) begin
         bit rd, wr;
         rd = r && (mcnt[i] > 0);
         wr = w && ((mcnt[i] < D[i]) || rd);
         if (rd) begin
            if (!FW[i]) mdout[i] = mm[i][mhead[i]];
            mhead[i] = (mhead[i] + 1) % D[i];
            mcnt[i]--;
         end
         if (wr) begin
            mm[i][(mhead[i] + mcnt[i]) % D[i]] = d;
            mcnt[i]++;
         end
         movf[i] = (w && !wr) ? 1'b1 : (clr ? 1'b0 : movf[i]);
         mudf[i] = (r && !rd) ? 1'b1 : (clr ? 1'b0 : mudf[i]);
      end
   endtask

   task automatic check_all(input string ph);
      for (int i = 0; i < 3; i++) begin
         int exp_d;
         if (FW[i]) exp_d = (mcnt[i] > 0) ? int'(mm[i][mhead[i]]) : 0;
         else       exp_d = int'(mdout[i]);
         chk($sformatf("%s.u%0d.count", ph, i), get_cnt(i), mcnt[i]);
         chk($sformatf("%s.u%0d.data_out", ph, i), int'(dout[i]), exp_d);
         chk($sformatf("%s.u%0d.full", ph, i), int'(full[i]), int'(mcnt[i] == D[i]));
         chk($sformatf("%s.u%0d.empty", ph, i), int'(empty[i]), int'(mcnt[i] == 0));
         chk($sformatf("%s.u%0d.almost_full", ph, i), int'(afull[i]), int'(mcnt[i] >= AF[i]));
         chk($sformatf("%s.u%0d.almost_empty", ph, i), int'(aempty[i]), int'(mcnt[i] <= AE[i]));
         chk($sformatf("%s.u%0d.overflow", ph, i), int'(ovf[i]), int'(movf[i]));
         chk($sformatf("%s.u%0d.underflow", ph, i), int'(udf[i]), int'(mudf[i]));
      end
   endtask

   // Drive one cycle's inputs, let the edge happen, then compare.
   task automatic cyc(input string ph, input bit w, input bit r, input logic [7:0] d, input bit clr);
      w_en = w; r_en = r; data_in = d; clr_err = clr;
      @(posedge clk);
      model_edge(w, r, d, clr);
      #1;
      check_all(ph);
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      rst = 1'b0;
      #2;

      // Fill 0x01..0x08, then overfill
      for (int k = 1; k <= 8; k++) cyc("fill", 1, 0, 8'(k), 0);
      cyc("overfill", 1, 0, 8'hFF, 0);
      // Simultaneous read+write on full
      cyc("full_rw", 1, 1, 8'hAA, 0);
      for (int k = 0; k < 9; k++) cyc("drain", 0, 1, 8'h00, 0);
      // Empty read, empty read+write, clear, clear vs new error
      cyc("clr_ovf", 0, 0, 8'h00, 1);
      cyc("empty_rd", 0, 1, 8'h00, 0);
      cyc("empty_rw", 1, 1, 8'h55, 0);
      cyc("rd55", 0, 1, 8'h00, 0);
      cyc("clr", 0, 0, 8'h00, 1);
      cyc("clr_vs_err", 0, 1, 8'h00, 1);
      cyc("clr2", 0, 0, 8'h00, 1);
      // Fall-through vs registered read of a single word
      cyc("w3c", 1, 0, 8'h3C, 0);
      cyc("idle", 0, 0, 8'h00, 0);
      cyc("r3c", 0, 1, 8'h00, 0);
      cyc("idle2", 0, 0, 8'h00, 0);
      // Interleaved traffic to wrap the depth-5 pointers
      for (int k = 0; k < 12; k++) begin
         cyc("wrap_w", 1, 0, 8'(8'h10 + k), 0);
         if (k % 3 == 2) begin
            cyc("wrap_r", 0, 1, 8'h00, 0);
            cyc("wrap_r", 0, 1, 8'h00, 0);
         end
      end
      while (mcnt[0] > 0) cyc("wrap_drain", 0, 1, 8'h00, 1);

      // Asynchronous reset between edges with 4 words stored
      for (int k = 0; k < 4; k++) cyc("pre_rst", 1, 0, 8'(8'hC0 + k), 0);
      cyc("pre_rst_err", 0, 0, 8'h00, 0);
      w_en = 1'b1; data_in = 8'hEE;
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_all("async_rst");
      #1 rst = 1'b0;
      w_en = 1'b0;
      #1;

      // Randomized traffic in phases of varying write/read bias
      for (int ph = 0; ph < 12; ph++) begin
         int wp, rp;
         wp = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 25 : 50;
         rp = (ph % 3 == 0) ? 25 : (ph % 3 == 1) ? 80 : 50;
         for (int k = 0; k < 200; k++) begin
            cyc("rand",
                $urandom_range(99) < wp,
                $urandom_range(99) < rp,
                8'($urandom),
                $urandom_range(15) == 0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
